fetch_unit: RTL and testbench

//  Instruction fetch stage: owns the PC, issues word requests to instruction memory, buffers

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_buffer.sv | 61 ++++++
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch FSM states (boot, run, misalignment trap)
//   NOP_INSTR     : word presented to decode while the buffer is empty (addi x0,x0,0)
//   fetch_entry_t : buffered instruction word with its PC
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_TRAP
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Instruction buffer for the fetch stage: BUF_DEPTH-entry FIFO of fetch_entry_t.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_entry  write one entry (caller guarantees space)
//   pop               retire the head entry (caller guarantees non-empty)
//   flush             drop all entries; overrides push/pop in the same cycle
//   head_entry        oldest entry (undefined while empty)
//   count, full, empty occupancy status
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2,
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1),
  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  fetch_entry_t    push_entry,
  input  logic            pop,
  input  logic            flush,
  output fetch_entry_t    head_entry,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty
);

  fetch_entry_t    mem_q [BUF_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(BUF_DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == CntW'(BUF_DEPTH));

  // The fetch credit rule must never let a push land on a full buffer.
  assert property (@(posedge clk) disable iff (rst || flush) !(push && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction memory,
// buffers returned words and presents {instr, pc} to decode. Redirects from execute
// flush the buffer and drop words still in flight.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr  request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data    in-order responses, no backpressure
//   id_valid/ready, id_instr, id_pc  instruction handed to decode
//   redirect_valid, redirect_pc      taken branch / jump from execute
//   fetch_misalign                   sticky misaligned-redirect flag
// Build option: define MISALIGN_TRAP_EN to trap on misaligned redirect targets; otherwise
// the two low target bits are cleared and fetch_misalign stays 0.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [DATA_WIDTH-1:0] id_pc,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  fetch_misalign
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  // PC of the next live response; responses return in order and every live request since
  // the last redirect is contiguous, so one running tag replaces a full tag queue.
  logic [DATA_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0]       inflight_q, inflight_d;
  logic [CntW-1:0]       discard_q, discard_d;
  logic                  misalign_q, misalign_d;

  logic [DATA_WIDTH-1:0] target;
  logic                  target_misaligned;

`ifdef MISALIGN_TRAP_EN
  assign target            = redirect_pc;
  assign target_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_pc[1:0];
  assign target             = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign target_misaligned  = 1'b0;
`endif

  fetch_entry_t    push_entry, head_entry;
  logic [CntW-1:0] buf_count;
  logic            buf_full, buf_empty;
  logic            rsp_live, req_fire;
  logic [CntW:0]   occupancy;

  assign occupancy = {1'b0, inflight_q} + {1'b0, buf_count};

  // Requests are withheld during a redirect so the memory never sees a wrong-path handshake.
  assign imem_req_valid = (state_q == S_RUN) && (occupancy < (CntW + 1)'(BUF_DEPTH)) &&
                          !redirect_valid;
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_live         = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
  assign push_entry.instr = imem_rsp_data;
  assign push_entry.pc    = rsp_pc_q;

  fetch_buffer #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (rsp_live),
    .push_entry (push_entry),
    .pop        (id_valid && id_ready),
    .flush      (redirect_valid),
    .head_entry (head_entry),
    .count      (buf_count),
    .full       (buf_full),
    .empty      (buf_empty)
  );

  assign id_valid       = !buf_empty;
  assign id_instr       = buf_empty ? NOP_INSTR : head_entry.instr;
  assign id_pc          = buf_empty ? '0 : head_entry.pc;
  assign fetch_misalign = misalign_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    misalign_d = misalign_q;

    if (state_q == S_BOOT) begin
      state_d = S_RUN;
    end

    if (req_fire) begin
      pc_d       = pc_q + DATA_WIDTH'(4);
      inflight_d = inflight_q + CntW'(1);
    end

    if (imem_rsp_valid) begin
      inflight_d = inflight_d - CntW'(1);
      if (discard_q != '0) begin
        discard_d = discard_q - CntW'(1);
      end else if (!redirect_valid) begin
        rsp_pc_d = rsp_pc_q + DATA_WIDTH'(4);
      end
    end

    if (redirect_valid) begin
      pc_d       = target;
      rsp_pc_d   = target;
      // Everything still outstanding after this cycle is wrong-path, including words
      // already counted for an earlier redirect.
      discard_d  = inflight_d;
      misalign_d = target_misaligned;
      state_d    = target_misaligned ? S_TRAP : S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      misalign_q <= misalign_d;
    end
  end

  logic unused_full;
  assign unused_full = buf_full;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency in-order memory model.
// Define MISALIGN_TRAP_EN for both RTL and bench to exercise the trap build.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_misalign;

  always #5 clk = ~clk;

  fetch_unit #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0),
    .BUF_DEPTH  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_misalign (fetch_misalign)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mem_lat = 1;
  int          due_q[$];
  logic [31:0] data_q[$];

  logic        obs_req_valid, obs_acc, obs_rsp, obs_id_valid, obs_id_fire, obs_misalign;
  logic [31:0] obs_addr, obs_id_pc, obs_id_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // One clock: present any due response, settle, snapshot outputs, advance to next negedge.
  task automatic cycle();
    if (rst) begin
      due_q.delete();
      data_q.delete();
    end
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data_q[0];
      void'(due_q.pop_front());
      void'(data_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    obs_req_valid = imem_req_valid;
    obs_acc       = imem_req_valid && imem_req_ready;
    obs_addr      = imem_addr;
    obs_rsp       = imem_rsp_valid;
    obs_id_valid  = id_valid;
    obs_id_fire   = id_valid && id_ready && !redirect_valid;
    obs_id_pc     = id_pc;
    obs_id_instr  = id_instr;
    obs_misalign  = fetch_misalign;
    if (!rst && obs_acc) begin
      due_q.push_back(cyc + mem_lat);
      data_q.push_back(mem_word(imem_addr));
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_id(output logic fired, output logic [31:0] pc, output logic [31:0] ins);
    fired = 1'b0;
    pc    = '0;
    ins   = '0;
    for (int n = 0; n < 20 && !fired; n++) begin
      cycle();
      if (obs_id_fire) begin
        fired = 1'b1;
        pc    = obs_id_pc;
        ins   = obs_id_instr;
      end
    end
  endtask

  // Redirect to base with requests blocked, then let every outstanding word drain.
  task automatic start_at(input logic [31:0] base);
    imem_req_ready = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = base;
    cycle();
    redirect_valid = 1'b0;
    repeat (6) cycle();
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    repeat (2) cycle();
    checks++;
    if (obs_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_req_valid: got %b want 0", obs_req_valid);
    end
    checks++;
    if (obs_id_valid !== 1'b0) begin
      errors++; $display("FAIL reset_id_valid: got %b want 0", obs_id_valid);
    end
    checks++;
    if (obs_id_instr !== NOP) begin
      errors++; $display("FAIL reset_id_instr: got %h want %h", obs_id_instr, NOP);
    end
    checks++;
    if (obs_id_pc !== 32'h0) begin
      errors++; $display("FAIL reset_id_pc: got %h want 0", obs_id_pc);
    end
    checks++;
    if (obs_addr !== 32'h0) begin
      errors++; $display("FAIL reset_imem_addr: got %h want 0", obs_addr);
    end
    checks++;
    if (obs_misalign !== 1'b0) begin
      errors++; $display("FAIL reset_misalign: got %b want 0", obs_misalign);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (obs_req_valid !== 1'b0) begin
      errors++; $display("FAIL boot_no_request: got %b want 0", obs_req_valid);
    end
  endtask

  task automatic test_sequential();
    logic        f;
    logic [31:0] pc, ins, want;
    cycle();
    checks++;
    if (obs_acc !== 1'b1 || obs_addr !== 32'h0) begin
      errors++; $display("FAIL first_request: acc=%b addr=%h want acc=1 addr=0", obs_acc, obs_addr);
    end
    for (int k = 0; k < 4; k++) begin
      want = 32'(k * 4);
      wait_id(f, pc, ins);
      checks++;
      if (!f || pc !== want || ins !== mem_word(want)) begin
        errors++;
        $display("FAIL seq_id%0d: fired=%b pc=%h instr=%h want pc=%h instr=%h",
                 k, f, pc, ins, want, mem_word(want));
      end
    end
  endtask

  task automatic test_id_stall();
    logic        f;
    logic [31:0] pc, ins;
    logic [31:0] want [3];
    int          n_acc;
    want[0] = 32'h40; want[1] = 32'h44; want[2] = 32'h48;
    start_at(32'h40);
    imem_req_ready = 1'b1;
    id_ready       = 1'b0;
    n_acc          = 0;
    repeat (5) begin
      cycle();
      n_acc += int'(obs_acc);
    end
    checks++;
    if (n_acc != 2) begin
      errors++; $display("FAIL stall_requests: got %0d want 2", n_acc);
    end
    checks++;
    if (obs_id_valid !== 1'b1 || obs_addr !== 32'h48) begin
      errors++; $display("FAIL stall_state: id_valid=%b addr=%h want 1 and 48", obs_id_valid, obs_addr);
    end
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_id(f, pc, ins);
      checks++;
      if (!f || pc !== want[k] || ins !== mem_word(want[k])) begin
        errors++;
        $display("FAIL stall_resume%0d: fired=%b pc=%h instr=%h want pc=%h", k, f, pc, ins, want[k]);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    logic        f;
    logic [31:0] pc, ins;
    int          n_acc;
    mem_lat = 3;
    start_at(32'h80);
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    n_acc          = 0;
    repeat (2) begin
      cycle();
      n_acc += int'(obs_acc);
    end
    checks++;
    if (n_acc != 2) begin
      errors++; $display("FAIL inflight_setup: got %0d requests want 2", n_acc);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    wait_id(f, pc, ins);
    checks++;
    if (!f || pc !== 32'h100 || ins !== mem_word(32'h100)) begin
      errors++; $display("FAIL redirect_first: fired=%b pc=%h instr=%h want pc=100", f, pc, ins);
    end
    wait_id(f, pc, ins);
    checks++;
    if (!f || pc !== 32'h104 || ins !== mem_word(32'h104)) begin
      errors++; $display("FAIL redirect_second: fired=%b pc=%h instr=%h want pc=104", f, pc, ins);
    end
    mem_lat = 1;
  endtask

  task automatic test_redirect_collide();
    logic        f;
    logic [31:0] pc, ins;
    start_at(32'h180);
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    repeat (2) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    cycle();
    redirect_valid = 1'b0;
    checks++;
    if (obs_rsp !== 1'b1 || obs_id_valid !== 1'b1 || obs_id_pc !== 32'h180) begin
      errors++;
      $display("FAIL collide_setup: rsp=%b id_valid=%b id_pc=%h want 1 1 180",
               obs_rsp, obs_id_valid, obs_id_pc);
    end
    wait_id(f, pc, ins);
    checks++;
    if (!f || pc !== 32'h300 || ins !== mem_word(32'h300)) begin
      errors++; $display("FAIL collide_first: fired=%b pc=%h instr=%h want pc=300", f, pc, ins);
    end
    wait_id(f, pc, ins);
    checks++;
    if (!f || pc !== 32'h304) begin
      errors++; $display("FAIL collide_second: fired=%b pc=%h want 304", f, pc);
    end
  endtask

  task automatic test_req_stall();
    logic        f;
    logic [31:0] pc, ins;
    start_at(32'h400);
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    repeat (3) cycle();
    imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (obs_addr !== 32'h408 || obs_req_valid !== 1'b1) begin
        errors++;
        $display("FAIL req_stall_hold%0d: addr=%h valid=%b want 408 1", k, obs_addr, obs_req_valid);
      end
    end
    checks++;
    if (obs_id_valid !== 1'b0 || obs_id_instr !== NOP) begin
      errors++; $display("FAIL req_stall_empty: id_valid=%b instr=%h want 0 %h", obs_id_valid, obs_id_instr, NOP);
    end
    imem_req_ready = 1'b1;
    wait_id(f, pc, ins);
    checks++;
    if (!f || pc !== 32'h408) begin
      errors++; $display("FAIL req_stall_resume: fired=%b pc=%h want 408", f, pc);
    end
  endtask

  task automatic test_misalign();
    logic        f;
    logic [31:0] pc, ins;
    start_at(32'h500);
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    cycle();
    redirect_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (obs_misalign !== 1'b1 || obs_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL trap_hold%0d: misalign=%b req_valid=%b want 1 0", k, obs_misalign, obs_req_valid);
      end
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    checks++;
    if (obs_misalign !== 1'b0 || obs_req_valid !== 1'b1) begin
      errors++; $display("FAIL trap_exit: misalign=%b req_valid=%b want 0 1", obs_misalign, obs_req_valid);
    end
    wait_id(f, pc, ins);
    checks++;
    if (!f || pc !== 32'h200 || ins !== mem_word(32'h200)) begin
      errors++; $display("FAIL trap_resume: fired=%b pc=%h want 200", f, pc);
    end
`else
    cycle();
    checks++;
    if (obs_misalign !== 1'b0) begin
      errors++; $display("FAIL misalign_tied: got %b want 0", obs_misalign);
    end
    wait_id(f, pc, ins);
    checks++;
    if (!f || pc !== 32'h100 || ins !== mem_word(32'h100)) begin
      errors++; $display("FAIL misalign_forced: fired=%b pc=%h want 100", f, pc);
    end
    wait_id(f, pc, ins);
    checks++;
    if (!f || pc !== 32'h104) begin
      errors++; $display("FAIL misalign_next: fired=%b pc=%h want 104", f, pc);
    end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequential();
    test_id_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_req_stall();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
